// File: rtl/edge_detector_bank.sv
// Multi-channel input conditioner: synchroniser, glitch filter, edge qualification,
// one-cycle event pulses and sticky pending/overflow flags with an aggregated interrupt.
module edge_detector_bank #(
  parameter int                  CHANNELS      = 8,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_LEVEL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overflow,
  output logic                irq
);

  // With the filter bypassed the level register itself acts as the final
  // synchroniser stage, so the input step still lands after SYNC_STAGES edges.
  localparam int CHAIN = (FILTER_CYCLES == 0) ? SYNC_STAGES - 1 : SYNC_STAGES;
  localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

  logic [CHANNELS-1:0] sync_reg [CHAIN];
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] level_reg, level_next;
  logic [CHANNELS-1:0] pulse_reg, pulse_next;
  logic [CHANNELS-1:0] pending_reg, pending_next;
  logic [CHANNELS-1:0] overflow_reg, overflow_next;
  logic [CHANNELS-1:0] toggle;
  logic [CHANNELS-1:0] qual_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < CHAIN; s++) sync_reg[s] <= RESET_LEVEL;
    end else begin
      sync_reg[0] <= in;
      for (int s = 1; s < CHAIN; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  assign sync = sync_reg[CHAIN-1];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      if (FILTER_CYCLES == 0) begin : g_bypass
        assign toggle[gi] = sync[gi] ^ level_reg[gi];
      end else begin : g_filter
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic             differs;

        assign differs    = sync[gi] ^ level_reg[gi];
        assign toggle[gi] = differs && (cnt_reg == CNT_LAST);

        always_comb begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (!differs || toggle[gi]) cnt_next = '0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) cnt_reg <= '0;
          else        cnt_reg <= cnt_next;
        end
      end

      // Enables are looked at only in the cycle the level update is decided.
      assign qual_edge[gi] = toggle[gi] &
                             ((~level_reg[gi] & rise_en[gi]) | (level_reg[gi] & fall_en[gi]));
    end
  endgenerate

  always_comb begin
    level_next    = level_reg ^ toggle;
    pulse_next    = qual_edge;
    // A new event beats a simultaneous clear; overflow only when nothing clears it.
    pending_next  = qual_edge | (pending_reg & ~clear);
    overflow_next = ~clear & (overflow_reg | (qual_edge & pending_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg    <= RESET_LEVEL;
      pulse_reg    <= '0;
      pending_reg  <= '0;
      overflow_reg <= '0;
    end else begin
      level_reg    <= level_next;
      pulse_reg    <= pulse_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  assign level_out = level_reg;
  assign pulse_out = pulse_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;
  assign irq       = |pending_reg;

endmodule

// File: tb/tb_edge_detector_bank.sv
// Bench for edge_detector_bank: a filtered (4-cycle) and a bypassed-filter instance,
// checked every cycle against a scoreboard of expected level/pulse events.
module tb_edge_detector_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_v   [2];
  logic [7:0] rise_v [2];
  logic [7:0] fall_v [2];
  logic [7:0] clr_v  [2];
  logic [7:0] lvl_o  [2];
  logic [7:0] pul_o  [2];
  logic [7:0] pend_o [2];
  logic [7:0] ovf_o  [2];
  logic       irq_o  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int   due;
    int   d;
    int   ch;
    logic lvl;
    bit   pulse;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    int ch;
    int width;
    bit ren;
    bit fen;
    bit pass0;
    bit rp0;
    bit fp0;
    bit rp1;
    bit fp1;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] exp_lvl [2];
  logic [7:0] exp_pul [2];
  logic [7:0] pend_m  [2];
  logic [7:0] ovf_m   [2];
  logic [7:0] clr_s   [2];

  edge_detector_bank #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_LEVEL(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in_v[0]), .rise_en(rise_v[0]), .fall_en(fall_v[0]),
    .clear(clr_v[0]), .level_out(lvl_o[0]), .pulse_out(pul_o[0]), .pending(pend_o[0]),
    .overflow(ovf_o[0]), .irq(irq_o[0])
  );

  edge_detector_bank #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_LEVEL(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in_v[1]), .rise_en(rise_v[1]), .fall_en(fall_v[1]),
    .clear(clr_v[1]), .level_out(lvl_o[1]), .pulse_out(pul_o[1]), .pending(pend_o[1]),
    .overflow(ovf_o[1]), .irq(irq_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    clr_s[0] <= clr_v[0];
    clr_s[1] <= clr_v[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Level change expected SYNC_STAGES+FILTER_CYCLES edges after the next sampling edge.
  task automatic push(input int d, input int ch, input logic lvl, input bit pulse);
    ev_t e;
    e.due   = cyc + ((d == 0) ? 6 : 2);
    e.d     = d;
    e.ch    = ch;
    e.lvl   = lvl;
    e.pulse = pulse;
    sb.push_back(e);
  endtask

  // Per-cycle monitor: retire due events, advance the sticky-flag expectations, compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        exp_lvl[d] = '0;
        exp_pul[d] = '0;
        pend_m[d]  = '0;
        ovf_m[d]   = '0;
      end
    end else begin
      exp_pul[0] = '0;
      exp_pul[1] = '0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].due == cyc) begin
          exp_lvl[sb[k].d][sb[k].ch] = sb[k].lvl;
          if (sb[k].pulse) exp_pul[sb[k].d][sb[k].ch] = 1'b1;
          sb.delete(k);
        end
      end
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 8; c++) begin
          ovf_m[d][c]  = clr_s[d][c] ? 1'b0 : (ovf_m[d][c] | (exp_pul[d][c] & pend_m[d][c]));
          pend_m[d][c] = exp_pul[d][c] | (pend_m[d][c] & ~clr_s[d][c]);
        end
        check($sformatf("dut%0d level @%0d", d, cyc), lvl_o[d], exp_lvl[d]);
        check($sformatf("dut%0d pulse @%0d", d, cyc), pul_o[d], exp_pul[d]);
        check($sformatf("dut%0d pending @%0d", d, cyc), pend_o[d], pend_m[d]);
        check($sformatf("dut%0d overflow @%0d", d, cyc), ovf_o[d], ovf_m[d]);
        check($sformatf("dut%0d irq @%0d", d, cyc), irq_o[d], |pend_m[d]);
      end
    end
  end

  initial begin
    vecs[0] = '{ch: 3, width: 3,  ren: 1, fen: 0, pass0: 0, rp0: 0, fp0: 0, rp1: 1, fp1: 0};
    vecs[1] = '{ch: 3, width: 4,  ren: 1, fen: 0, pass0: 1, rp0: 1, fp0: 0, rp1: 1, fp1: 0};
    vecs[2] = '{ch: 6, width: 1,  ren: 1, fen: 1, pass0: 0, rp0: 0, fp0: 0, rp1: 1, fp1: 1};
    vecs[3] = '{ch: 6, width: 8,  ren: 0, fen: 1, pass0: 1, rp0: 0, fp0: 1, rp1: 0, fp1: 1};
    vecs[4] = '{ch: 1, width: 5,  ren: 0, fen: 0, pass0: 1, rp0: 0, fp0: 0, rp1: 0, fp1: 0};
    vecs[5] = '{ch: 7, width: 12, ren: 1, fen: 1, pass0: 1, rp0: 1, fp0: 1, rp1: 1, fp1: 1};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_v[d]   = '0;
      rise_v[d] = 8'hFF;
      fall_v[d] = '0;
      clr_v[d]  = '0;
    end
    repeat (3) tick();
    check("reset level", lvl_o[0], 8'h00);
    check("reset pulse", pul_o[0], 8'h00);
    check("reset pending", pend_o[0], 8'h00);
    check("reset irq", irq_o[0], 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clean rising step on channel 0, latency 6 (filtered) and 2 (bypassed).
    in_v[0][0] = 1'b1;
    in_v[1][0] = 1'b1;
    push(0, 0, 1'b1, 1'b1);
    push(1, 0, 1'b1, 1'b1);
    repeat (5) tick();
    check("t1 level before latency", lvl_o[0][0], 1'b0);
    tick();
    check("t1 level at latency", lvl_o[0][0], 1'b1);
    check("t1 pulse at latency", pul_o[0][0], 1'b1);
    check("t1 pending", pend_o[0][0], 1'b1);
    check("t1 irq", irq_o[0], 1'b1);
    tick();
    check("t1 pulse one cycle", pul_o[0][0], 1'b0);
    in_v[0][0] = 1'b0;
    in_v[1][0] = 1'b0;
    push(0, 0, 1'b0, 1'b0);
    push(1, 0, 1'b0, 1'b0);
    repeat (10) tick();

    // Table of pulse trains: glitches, edge qualification, level-only tracking.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        rise_v[d][vecs[i].ch] = vecs[i].ren;
        fall_v[d][vecs[i].ch] = vecs[i].fen;
      end
      tick();
      in_v[0][vecs[i].ch] = 1'b1;
      in_v[1][vecs[i].ch] = 1'b1;
      if (vecs[i].pass0) push(0, vecs[i].ch, 1'b1, vecs[i].rp0);
      push(1, vecs[i].ch, 1'b1, vecs[i].rp1);
      repeat (vecs[i].width) tick();
      in_v[0][vecs[i].ch] = 1'b0;
      in_v[1][vecs[i].ch] = 1'b0;
      if (vecs[i].pass0) push(0, vecs[i].ch, 1'b0, vecs[i].fp0);
      push(1, vecs[i].ch, 1'b0, vecs[i].fp1);
      repeat (14) tick();
      check($sformatf("vec%0d final level", i), lvl_o[0][vecs[i].ch], 1'b0);
    end

    // Any-edge channel 5 with overflow, then software clear.
    clr_v[0] = 8'hFF;
    clr_v[1] = 8'hFF;
    tick();
    clr_v[0] = '0;
    clr_v[1] = '0;
    check("t3 irq after clear all", irq_o[0], 1'b0);
    rise_v[0][5] = 1'b1;
    fall_v[0][5] = 1'b1;
    in_v[0][5]   = 1'b1;
    push(0, 5, 1'b1, 1'b1);
    repeat (20) tick();
    in_v[0][5] = 1'b0;
    push(0, 5, 1'b0, 1'b1);
    repeat (6) tick();
    check("t3 second pulse", pul_o[0][5], 1'b1);
    check("t3 overflow", ovf_o[0][5], 1'b1);
    check("t3 pending", pend_o[0][5], 1'b1);
    tick();
    clr_v[0] = 8'h20;
    tick();
    clr_v[0] = '0;
    check("t3 pending cleared", pend_o[0][5], 1'b0);
    check("t3 overflow cleared", ovf_o[0][5], 1'b0);
    check("t3 irq cleared", irq_o[0], 1'b0);

    // Clear coinciding with a qualified edge while already pending.
    rise_v[0][2] = 1'b1;
    fall_v[0][2] = 1'b1;
    in_v[0][2]   = 1'b1;
    push(0, 2, 1'b1, 1'b1);
    repeat (10) tick();
    in_v[0][2] = 1'b0;
    push(0, 2, 1'b0, 1'b1);
    repeat (5) tick();
    clr_v[0][2] = 1'b1;
    tick();
    clr_v[0][2] = 1'b0;
    check("t4 pulse", pul_o[0][2], 1'b1);
    check("t4 pending kept", pend_o[0][2], 1'b1);
    check("t4 overflow suppressed", ovf_o[0][2], 1'b0);
    repeat (4) tick();

    // Bypassed filter: all channels step together.
    rise_v[1] = 8'hFF;
    fall_v[1] = 8'h00;
    in_v[1]   = 8'hFF;
    for (int c = 0; c < 8; c++) push(1, c, 1'b1, 1'b1);
    repeat (2) tick();
    check("t5 all pulses", pul_o[1], 8'hFF);
    check("t5 all levels", lvl_o[1], 8'hFF);
    tick();
    check("t5 pulses end", pul_o[1], 8'h00);
    in_v[1] = 8'h00;
    for (int c = 0; c < 8; c++) push(1, c, 1'b0, 1'b0);
    repeat (5) tick();

    // Reset in the middle of a filter count.
    rise_v[0][7] = 1'b1;
    in_v[0][7]   = 1'b1;
    push(0, 7, 1'b1, 1'b1);
    repeat (8) tick();
    check("t6 pending before reset", pend_o[0] != 8'h00, 1'b1);
    rise_v[0][4] = 1'b1;
    in_v[0][4]   = 1'b1;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    check("t6 reset level", lvl_o[0], 8'h00);
    check("t6 reset pulse", pul_o[0], 8'h00);
    check("t6 reset pending", pend_o[0], 8'h00);
    check("t6 reset overflow", ovf_o[0], 8'h00);
    check("t6 reset irq", irq_o[0], 1'b0);
    check("t6 reset irq dut1", irq_o[1], 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    push(0, 7, 1'b1, 1'b1);
    push(0, 4, 1'b1, 1'b1);
    repeat (5) tick();
    check("t6 level before latency", lvl_o[0][4], 1'b0);
    tick();
    check("t6 level after restart", lvl_o[0], 8'h90);
    check("t6 pulse after restart", pul_o[0], 8'h90);
    repeat (3) tick();

    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detector_bank.md
Name: edge_detector_bank

Overview:
Multi-channel edge detector and event latch for asynchronous external inputs (buttons, handshake lines, status pins) feeding the control logic. Each channel has a configurable synchroniser, a glitch filter and per-channel rising/falling/any-edge qualification. Each channel also has a one-cycle event pulse and a sticky pending flag with software clear and overflow detection. A single aggregated interrupt line is provided.

Parameters:
CHANNELS, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
FILTER_CYCLES, 4, consecutive cycles a synchronised value must differ from the filtered level before the level changes; 0 = filter bypassed
RESET_LEVEL, 0, CHANNELS-bit value loaded into synchroniser and filtered-level registers at reset

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in  input  CHANNELS  raw asynchronous inputs
rise_en  input  CHANNELS  per-channel: qualify 0->1 transitions of filtered level
fall_en  input  CHANNELS  per-channel: qualify 1->0 transitions of filtered level
clear  input  CHANNELS  per-channel synchronous clear of pending/overflow
level_out  output  CHANNELS  filtered, synchronised level
pulse_out  output  CHANNELS  one-cycle pulse per qualified edge
pending  output  CHANNELS  sticky flag, set by qualified edge
overflow  output  CHANNELS  sticky flag, qualified edge while pending already set
irq  output  1  OR of all pending bits

Behaviour:
- Reset (rst_n low, asynchronous): sync chain and level_out = RESET_LEVEL; filter counters = 0; pulse_out, pending, overflow = 0; irq = 0. Reset mid-filter discards the partial count.
- Synchroniser: per-channel SYNC_STAGES-deep shift register; the last stage is sync[i].
- Filter (FILTER_CYCLES>0):
  - Per-channel counter, width clog2(FILTER_CYCLES+1).
  - If sync==level_out, the counter is cleared to 0.
  - Otherwise, if counter==FILTER_CYCLES-1, level_out toggles and the counter clears.
  - Otherwise, the counter increments.
  - A glitch shorter than FILTER_CYCLES synchronised cycles never changes level_out.
- Filter (FILTER_CYCLES=0): level_out <= sync every cycle.
- Latency: a clean input step reaches level_out exactly SYNC_STAGES+FILTER_CYCLES rising edges after the first edge that samples the new value.
- Qualification: rise = level changing 0->1 with rise_en[i]; fall = 1->0 with fall_en[i]. Both enables set gives any-edge; neither set tracks level only, with no pulses or flags.
- Enables are sampled in the cycle the level update is decided, so a change takes effect on the next transition.
- pulse_out[i] is registered, high for exactly one cycle, and in the same cycle level_out first shows the new value.
- pending[i]: set on the qualified-edge update; cleared by clear[i]. If set and clear occur in the same cycle, set wins and pending stays 1.
- overflow[i]:
  - Set when a qualified edge occurs while pending[i]=1 and clear[i]=0.
  - Cleared by clear[i].
  - If clear and the edge coincide, overflow goes to 0 and pending stays 1.
- Power-up: RESET_LEVEL differing from the input level after reset yields a normal qualified edge after the latency. This is defined behaviour.
- irq is combinational OR of the pending registers; no additional latency.
- Channels are fully independent; simultaneous edges on any subset are all captured.

Test Plan:
1. CHANNELS=8, SYNC_STAGES=2, FILTER_CYCLES=4, rise_en=all, fall_en=0; in[0] 0->1 held -> level_out[0] and pulse_out[0] high exactly 6 edges later; pulse_out 1 cycle; pending[0]=1, irq=1.
2. Glitch: in[3] high for 3 cycles then low -> level_out[3], pulse_out[3] and pending[3] all stay 0. Then hold high for 4+ cycles -> edge reported.
3. Any-edge: rise_en[5]=fall_en[5]=1; in[5] 0->1, then 1->0 after 20 cycles -> two pulses. overflow[5]=1 after the second (no clear); clear[5] for 1 cycle -> pending[5]=overflow[5]=0, irq=0.
4. Clear collision: clear[2] asserted in the same cycle as a qualified edge pulse on ch2 -> pending[2]=1, overflow[2]=0.
5. FILTER_CYCLES=0 build: in[1] step -> level_out[1] changes 2 edges later. Simultaneous steps on all 8 channels -> pulse_out=8'hFF for one cycle.
6. Reset mid-filter: assert rst_n=0 two cycles into a filter count -> all outputs return to reset values immediately, counter restarts from 0 after release.
